uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of word requesters (range 2..8).
REQ-002 Parameter WORD_W, default 32, requester word width (multiple of 8).
REQ-003 iGlobalClock  input  1  single clock for all logic; the UART clock domain.
REQ-004 iGlobalReset  input  1  asynchronous, active-low reset.
REQ-005 iReqValid  input  NUM_REQ  per-requester word-ready flag.
REQ-006 iReqWord  input  NUM_REQ*WORD_W  concatenated words; requester k occupies bits [k*WORD_W +: WORD_W].
REQ-007 oReqAck  output  NUM_REQ  one-cycle pulse; the word of requester k has been captured.
REQ-008 iTxBufferFull  input  1  UART transmitter FIFO full; no byte write is allowed while high.
REQ-009 oUartTx  output  8  byte presented to the UART transmitter write port.
REQ-010 oByteTransmit  output  1  one-cycle byte write strobe; oUartTx is valid when high.
REQ-011 oBusy  output  1  high while a word (or frame) is being serialized.
REQ-012 oGrant  output  3  index of the requester currently being served; holds the last granted value when idle.

Function
REQ-013 The FSM SHALL have the states IDLE, CAPTURE and SEND.
REQ-014 IDLE: if any iReqValid bit is high, go to CAPTURE; otherwise stay in IDLE.
REQ-015 CAPTURE: perform a round-robin grant starting at the index after the last served requester, latch that requester's word, pulse its oReqAck for exactly one cycle, then go to SEND.
REQ-016 After a reset, requester 0 SHALL have the highest priority.
REQ-017 SEND: serialize the word most-significant byte first, for WORD_W/8 bytes.
REQ-018 A byte SHALL be written (oByteTransmit=1) only in a cycle where iTxBufferFull=0.
REQ-019 If iTxBufferFull=1, hold the byte index and oUartTx, and keep oByteTransmit=0.
REQ-020 Consecutive writes on back-to-back cycles are permitted.
REQ-021 After the last byte is written, go to IDLE and advance the round-robin pointer to oGrant+1, modulo NUM_REQ.
REQ-022 Latency: a valid request sampled in IDLE at edge N SHALL give oReqAck at N+1 and the first oByteTransmit at N+2, if the buffer is not full.
REQ-023 A requester SHALL change or drop iReqValid in the cycle after its ack; the block does not re-sample a word that has already been acked.
REQ-024 iReqValid changes during SEND SHALL NOT affect the word in flight.
REQ-025 A requester whose iReqValid is still high after its ack is re-arbitrated fairly; the maximum wait is NUM_REQ-1 words.
REQ-026 The internal byte counter SHALL be $clog2(WORD_W/8)+1 bits wide.
REQ-027 oBusy=1 in CAPTURE and SEND, and 0 in IDLE.

Reset
REQ-028 Asserting iGlobalReset at any time, including mid-word, SHALL abort the transfer immediately: state=IDLE, oUartTx=0, oByteTransmit=0, oReqAck=0, oBusy=0, oGrant=0, round-robin pointer=0.
REQ-029 A partially sent word is not resumed after reset.
REQ-030 Reset deassertion SHALL be synchronized to iGlobalClock before the FSM leaves IDLE.

Configuration
REQ-031 Macro UART_TX_ARB_FRAME_EN.
- Defined: each word is preceded by one header byte, 8'hA0 | grant index, written under the same full/strobe rules; frame length = WORD_W/8+1 bytes.
- Undefined: no header is sent; frame length = WORD_W/8 bytes; the header logic is absent.

Structure
REQ-032 The following SHALL go in the shared definitions package:
- FSM state encodings;
- header constant 8'hA0;
- byte width constant (equal to the existing UART byte-size definition).
REQ-033 One sub-module, rr_arbiter, SHALL hold the round-robin grant logic (request vector plus pointer in; one-hot grant plus index out).
REQ-034 Serialization and the FSM SHALL stay in uart_tx_arbiter.

Verification
REQ-035 Single word: requester 0 sends 32'h11223344, buffer never full -> ack at N+1; bytes 11,22,33,44 written on cycles N+2..N+5; oBusy falls after the last write.
REQ-036 Contention: both requesters valid continuously with distinct words -> words served alternately 0,1,0,1; each ack is one cycle wide.
REQ-037 Back-pressure: iTxBufferFull held high for 5 cycles after the second byte -> no strobe while full; the third byte 33 is written on the first cycle after full drops; no byte is lost or duplicated.
REQ-038 Reset mid-word: iGlobalReset asserted low after 2 bytes -> all outputs are 0 in the same cycle; after release, a request from requester 1 alone restarts from its MSB.
REQ-039 UART_TX_ARB_FRAME_EN defined: requester 1 sends 32'hDEADBEEF -> bytes A1,DE,AD,BE,EF written.
REQ-040 Idle: no valid inputs for 100 cycles -> oByteTransmit, oReqAck and oBusy all stay 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, byte width
// and the frame header constant used when UART_TX_ARB_FRAME_EN is defined.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  localparam int UART_BYTE_W = 8;
  localparam logic [7:0] HDR_BYTE = 8'hA0;

  function automatic logic [7:0] header_byte(input logic [2:0] idx);
    return HDR_BYTE | {5'd0, idx};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin grant: the first requester at or after ptr wins, then wraps to
// the indices below ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         grant_idx,
  output logic               any_req
);

  localparam int IW = $clog2(NUM_REQ);

  // Two passes: indices from ptr upward first, then the wrapped lower indices.
  always_comb begin
    grant     = '0;
    grant_idx = 3'd0;
    any_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i[IW-1:0]] && (i >= int'(ptr))) begin
        any_req           = 1'b1;
        grant[i[IW-1:0]]  = 1'b1;
        grant_idx         = 3'(i);
      end else begin
        any_req = any_req;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req[i[IW-1:0]] && (i < int'(ptr))) begin
        any_req           = 1'b1;
        grant[i[IW-1:0]]  = 1'b1;
        grant_idx         = 3'(i);
      end else begin
        any_req = any_req;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ word requesters onto a byte-wide UART transmit port, MSB
// first. Define UART_TX_ARB_FRAME_EN to prefix each word with 8'hA0 | grant.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = 32
) (
  input  logic                      iGlobalClock,
  input  logic                      iGlobalReset,
  input  logic [NUM_REQ-1:0]        iReqValid,
  input  logic [NUM_REQ*WORD_W-1:0] iReqWord,
  output logic [NUM_REQ-1:0]        oReqAck,
  input  logic                      iTxBufferFull,
  output logic [7:0]                oUartTx,
  output logic                      oByteTransmit,
  output logic                      oBusy,
  output logic [2:0]                oGrant
);

  localparam int NUM_BYTES = WORD_W / UART_BYTE_W;
  localparam int CNT_W     = $clog2(NUM_BYTES) + 1;
`ifdef UART_TX_ARB_FRAME_EN
  localparam int FRAME_LEN = NUM_BYTES + 1;
`else
  localparam int FRAME_LEN = NUM_BYTES;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t              state_r, state_next_s;
  logic [1:0]          rst_sync_r;
  logic                run_s;
  logic [2:0]          ptr_r;
  logic [WORD_W-1:0]   word_r;
  logic [CNT_W-1:0]    byte_idx_r;
  logic [NUM_REQ-1:0]  grant_s;
  logic [NUM_REQ-1:0]  ack_next_s;
  logic [2:0]          grant_idx_s;
  logic                any_s;
  logic                wr_s;
  logic                last_s;
  logic [7:0]          byte_s;

  // Release of reset reaches the FSM only after two clean clock edges.
  always_ff @(posedge iGlobalClock or negedge iGlobalReset) begin
    if (!iGlobalReset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign run_s = rst_sync_r[1];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (iReqValid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_req   (any_s)
  );

  assign wr_s   = (state_r == ST_SEND) && !iTxBufferFull;
  assign last_s = (byte_idx_r == LAST_IDX);

  // Byte currently at the head of the frame.
  always_comb begin
    byte_s = word_r[WORD_W-1 -: UART_BYTE_W];
`ifdef UART_TX_ARB_FRAME_EN
    if (byte_idx_r == '0) begin
      byte_s = header_byte(oGrant);
    end else begin
      byte_s = word_r[WORD_W-1 -: UART_BYTE_W];
    end
`endif
  end

  // Next-state and acknowledge decode.
  always_comb begin
    state_next_s = state_r;
    ack_next_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (run_s && (|iReqValid)) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (any_s) begin
          state_next_s = ST_SEND;
          ack_next_s   = grant_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (wr_s && last_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SEND;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state, ack pulse and busy flag.
  always_ff @(posedge iGlobalClock or negedge iGlobalReset) begin
    if (!iGlobalReset) begin
      state_r <= ST_IDLE;
      oReqAck <= '0;
      oBusy   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      oReqAck <= ack_next_s;
      oBusy   <= (state_next_s != ST_IDLE);
    end
  end

  // Word capture, serialization and round-robin pointer update.
  always_ff @(posedge iGlobalClock or negedge iGlobalReset) begin
    if (!iGlobalReset) begin
      word_r        <= '0;
      byte_idx_r    <= '0;
      oGrant        <= 3'd0;
      ptr_r         <= 3'd0;
      oUartTx       <= 8'd0;
      oByteTransmit <= 1'b0;
    end else if ((state_r == ST_CAPTURE) && any_s) begin
      word_r        <= iReqWord[int'(grant_idx_s)*WORD_W +: WORD_W];
      byte_idx_r    <= '0;
      oGrant        <= grant_idx_s;
      oByteTransmit <= 1'b0;
    end else if (wr_s) begin
      oByteTransmit <= 1'b1;
      oUartTx       <= byte_s;
      byte_idx_r    <= byte_idx_r + CNT_W'(1);
`ifdef UART_TX_ARB_FRAME_EN
      if (byte_idx_r != '0) begin
        word_r <= word_r << UART_BYTE_W;
      end else begin
        word_r <= word_r;
      end
`else
      word_r <= word_r << UART_BYTE_W;
`endif
      if (last_s) begin
        ptr_r <= (oGrant == 3'(NUM_REQ - 1)) ? 3'd0 : oGrant + 3'd1;
      end else begin
        ptr_r <= ptr_r;
      end
    end else begin
      oByteTransmit <= 1'b0;
    end
  end

endmodule
